// File: rtl/alu_arbiter_pkg.sv
// Shared opcode encodings, FSM states and opcode legality helper for the
// ALU arbiter and the ALU it fronts.
package alu_arbiter_pkg;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_XOR  = 3'd2;
  localparam logic [2:0] OP_SLT  = 3'd3;
  localparam logic [2:0] OP_CNE  = 3'd4;
  localparam logic [2:0] OP_LAST = OP_CNE;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  function automatic logic is_legal_op(input logic [2:0] cmd);
    return cmd <= OP_LAST;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter; the pointer names the preferred requester and
// moves to the other one whenever a grant is accepted.
module rr_arbiter2 (
  input  logic clk,
  input  logic rst_n,
  input  logic req0,
  input  logic req1,
  input  logic accept,
  output logic grant0,
  output logic grant1,
  output logic grant_id
);

  logic ptr_q;

  // A lone requester always wins; the pointer only breaks ties.
  assign grant0   = req0 & (~req1 | ~ptr_q);
  assign grant1   = req1 & (~req0 |  ptr_q);
  assign grant_id = grant1;

  // NOTE: sequential state uses non-blocking assignment so every flop samples
  // pre-edge values regardless of the order blocks are evaluated in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= 1'b0;
    end else if (accept) begin
      ptr_q <= ~grant_id;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between two requesters: round-robin grant,
// registered ALU operands, SETTLE-cycle wait, registered response.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int SETTLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [2:0]       req0_cmd,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [2:0]       req1_cmd,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_carryout,
  output logic             rsp_zero,
  output logic             rsp_overflow,
  output logic             rsp_err,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_cmd,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_carryout,
  input  logic             alu_zero,
  input  logic             alu_overflow
);

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

  state_e           state_q, state_d;
  logic [3:0]       cnt_q;
  logic             grant0, grant1, grant_id;
  logic             idle, accept, sel_legal, settle_done;
  logic [2:0]       sel_cmd;
  logic [WIDTH-1:0] sel_a, sel_b;

  assign idle   = (state_q == ST_IDLE);
  assign accept = idle & (req0_valid | req1_valid);

  rr_arbiter2 u_rr (
    .clk      (clk),
    .rst_n    (rst_n),
    .req0     (req0_valid),
    .req1     (req1_valid),
    .accept   (accept),
    .grant0   (grant0),
    .grant1   (grant1),
    .grant_id (grant_id)
  );

  assign req0_ready  = idle & grant0;
  assign req1_ready  = idle & grant1;
  assign sel_cmd     = grant_id ? req1_cmd : req0_cmd;
  assign sel_a       = grant_id ? req1_a   : req0_a;
  assign sel_b       = grant_id ? req1_b   : req0_b;
  assign sel_legal   = is_legal_op(sel_cmd);
  assign settle_done = (cnt_q == SETTLE_LAST);
  assign rsp_valid   = (state_q == ST_RESP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: next state gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (accept) state_d = sel_legal ? ST_EXEC : ST_RESP;
      ST_EXEC: if (settle_done) state_d = ST_RESP;
      ST_RESP: if (rsp_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Operand and response registers; alu_* move only on a legal accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      alu_a        <= '0;
      alu_b        <= '0;
      alu_cmd      <= '0;
      rsp_id       <= 1'b0;
      rsp_result   <= '0;
      rsp_carryout <= 1'b0;
      rsp_zero     <= 1'b0;
      rsp_overflow <= 1'b0;
      rsp_err      <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (accept) begin
            rsp_id <= grant_id;
            cnt_q  <= '0;
            if (sel_legal) begin
              alu_a   <= sel_a;
              alu_b   <= sel_b;
              alu_cmd <= sel_cmd;
            end else begin
              rsp_err      <= 1'b1;
              rsp_result   <= '0;
              rsp_carryout <= 1'b0;
              rsp_zero     <= 1'b0;
              rsp_overflow <= 1'b0;
            end
          end
        end
        ST_EXEC: begin
          if (settle_done) begin
            rsp_result   <= alu_result;
            rsp_carryout <= alu_carryout;
            rsp_zero     <= alu_zero;
            rsp_overflow <= alu_overflow;
            rsp_err      <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural ALU on the alu_* side.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [2:0]  req0_cmd, req1_cmd, alu_cmd;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic        rsp_valid, rsp_ready, rsp_id;
  logic [31:0] rsp_result, alu_a, alu_b, alu_result;
  logic        rsp_carryout, rsp_zero, rsp_overflow, rsp_err;
  logic        alu_carryout, alu_zero, alu_overflow;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.WIDTH(32), .SETTLE(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_cmd(req0_cmd),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_cmd(req1_cmd),
    .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_carryout(rsp_carryout), .rsp_zero(rsp_zero),
    .rsp_overflow(rsp_overflow), .rsp_err(rsp_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_cmd(alu_cmd),
    .alu_result(alu_result), .alu_carryout(alu_carryout),
    .alu_zero(alu_zero), .alu_overflow(alu_overflow)
  );

  // Reference ALU: flags only for ADD/SUB, zeros otherwise.
  always_comb begin
    alu_result   = '0;
    alu_carryout = 1'b0;
    alu_zero     = 1'b0;
    alu_overflow = 1'b0;
    case (alu_cmd)
      3'd0: begin
        {alu_carryout, alu_result} = {1'b0, alu_a} + {1'b0, alu_b};
        alu_overflow = (alu_a[31] == alu_b[31]) && (alu_result[31] != alu_a[31]);
        alu_zero     = (alu_result == 32'd0);
      end
      3'd1: begin
        {alu_carryout, alu_result} = {1'b0, alu_a} + {1'b0, ~alu_b} + 33'd1;
        alu_overflow = (alu_a[31] != alu_b[31]) && (alu_result[31] != alu_a[31]);
        alu_zero     = (alu_result == 32'd0);
      end
      3'd2: alu_result = alu_a ^ alu_b;
      3'd3: alu_result = {31'd0, $signed(alu_a) < $signed(alu_b)};
      3'd4: alu_result = {31'd0, alu_a != alu_b};
      default: ;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic drive0(input logic v, input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
    req0_valid = v; req0_cmd = c; req0_a = a; req0_b = b;
  endtask

  task automatic drive1(input logic v, input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
    req1_valid = v; req1_cmd = c; req1_a = a; req1_b = b;
  endtask

  // Called at a negedge; returns at the first negedge with rsp_valid high.
  task automatic wait_rsp(input string tag, input int max_cycles);
    int n = 0;
    while (!rsp_valid && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_rsp_seen"}, 32'(rsp_valid), 32'd1);
  endtask

  initial begin
    rst_n     = 1'b0;
    rsp_ready = 1'b0;
    drive0(1'b0, 3'd0, 32'd0, 32'd0);
    drive1(1'b0, 3'd0, 32'd0, 32'd0);
    repeat (2) @(negedge clk);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_alu_a", alu_a, 32'd0);
    check("rst_alu_cmd", 32'(alu_cmd), 32'd0);
    check("rst_rsp_result", rsp_result, 32'd0);
    rst_n = 1'b1;

    // 1: single ADD, exact latency
    @(negedge clk);
    rsp_ready = 1'b1;
    drive0(1'b1, 3'd0, 32'd5, 32'd7);
    #1 check("t1_req0_ready", 32'(req0_ready), 32'd1);
    @(posedge clk); @(negedge clk);
    req0_valid = 1'b0;
    check("t1_exec_no_valid", 32'(rsp_valid), 32'd0);
    check("t1_alu_a", alu_a, 32'd5);
    check("t1_alu_b", alu_b, 32'd7);
    @(negedge clk);
    check("t1_rsp_valid_e1", 32'(rsp_valid), 32'd1);
    check("t1_result", rsp_result, 32'd12);
    check("t1_id", 32'(rsp_id), 32'd0);
    check("t1_err", 32'(rsp_err), 32'd0);
    @(negedge clk);
    check("t1_consumed", 32'(rsp_valid), 32'd0);

    // 2: simultaneous requests from a fresh pointer
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    drive0(1'b1, 3'd1, 32'd3, 32'd5);
    drive1(1'b1, 3'd2, 32'h0000_F0F0, 32'h0000_0FF0);
    #1 check("t2_req0_ready", 32'(req0_ready), 32'd1);
    check("t2_req1_wait", 32'(req1_ready), 32'd0);
    @(posedge clk); @(negedge clk);
    req0_valid = 1'b0;
    check("t2_busy_req1", 32'(req1_ready), 32'd0);
    wait_rsp("t2a", 20);
    check("t2a_id", 32'(rsp_id), 32'd0);
    check("t2a_result", rsp_result, 32'hFFFF_FFFE);
    @(negedge clk);
    check("t2_req1_ready", 32'(req1_ready), 32'd1);
    @(posedge clk); @(negedge clk);
    req1_valid = 1'b0;
    wait_rsp("t2b", 20);
    check("t2b_id", 32'(rsp_id), 32'd1);
    check("t2b_result", rsp_result, 32'h0000_FF00);
    @(negedge clk);

    // 3: backpressure with both requesters waiting
    rsp_ready = 1'b0;
    drive0(1'b1, 3'd0, 32'd1, 32'd2);
    drive1(1'b1, 3'd0, 32'd10, 32'd20);
    #1 check("t3_ptr0_req0", 32'(req0_ready), 32'd1);
    check("t3_ptr0_req1", 32'(req1_ready), 32'd0);
    @(posedge clk); @(negedge clk);
    wait_rsp("t3a", 20);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("t3_hold_valid%0d", i), 32'(rsp_valid), 32'd1);
      check($sformatf("t3_hold_result%0d", i), rsp_result, 32'd3);
      check($sformatf("t3_hold_id%0d", i), 32'(rsp_id), 32'd0);
      check($sformatf("t3_hold_rdy%0d", i), {30'd0, req0_ready, req1_ready}, 32'd0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check("t3_rr_req1", 32'(req1_ready), 32'd1);
    check("t3_rr_req0", 32'(req0_ready), 32'd0);
    @(posedge clk); @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    wait_rsp("t3b", 20);
    check("t3b_id", 32'(rsp_id), 32'd1);
    check("t3b_result", rsp_result, 32'd30);
    @(negedge clk);

    // 4: illegal opcode skips EXEC, leaves alu_* alone
    drive1(1'b1, 3'd6, 32'd1, 32'd1);
    #1 check("t4_req1_ready", 32'(req1_ready), 32'd1);
    @(posedge clk); @(negedge clk);
    req1_valid = 1'b0;
    check("t4_no_exec", 32'(rsp_valid), 32'd1);
    check("t4_err", 32'(rsp_err), 32'd1);
    check("t4_result", rsp_result, 32'd0);
    check("t4_flags", {29'd0, rsp_carryout, rsp_zero, rsp_overflow}, 32'd0);
    check("t4_id", 32'(rsp_id), 32'd1);
    check("t4_alu_cmd", 32'(alu_cmd), 32'd0);
    check("t4_alu_a", alu_a, 32'd10);
    @(negedge clk);
    check("t4_consumed", 32'(rsp_valid), 32'd0);

    // 5: signed overflow, then carry-out with zero result
    drive0(1'b1, 3'd0, 32'h7FFF_FFFF, 32'd1);
    @(posedge clk); @(negedge clk);
    req0_valid = 1'b0;
    wait_rsp("t5a", 20);
    check("t5a_result", rsp_result, 32'h8000_0000);
    check("t5a_cz_o", {29'd0, rsp_carryout, rsp_zero, rsp_overflow}, 32'b001);
    check("t5a_err", 32'(rsp_err), 32'd0);
    @(negedge clk);
    drive0(1'b1, 3'd0, 32'hFFFF_FFFF, 32'd1);
    @(posedge clk); @(negedge clk);
    req0_valid = 1'b0;
    wait_rsp("t5b", 20);
    check("t5b_result", rsp_result, 32'd0);
    check("t5b_cz_o", {29'd0, rsp_carryout, rsp_zero, rsp_overflow}, 32'b110);
    @(negedge clk);

    // 6: reset in EXEC clears outputs and the pointer (pointer is 1 here)
    drive0(1'b1, 3'd1, 32'd9, 32'd4);
    @(posedge clk); @(negedge clk);
    req0_valid = 1'b0;
    check("t6_in_exec_alu_a", alu_a, 32'd9);
    rst_n = 1'b0;
    #1 check("t6_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("t6_rst_alu_a", alu_a, 32'd0);
    check("t6_rst_alu_b", alu_b, 32'd0);
    check("t6_rst_alu_cmd", 32'(alu_cmd), 32'd0);
    @(negedge clk);
    check("t6_no_replay", 32'(rsp_valid), 32'd0);
    drive0(1'b1, 3'd0, 32'd2, 32'd2);
    drive1(1'b1, 3'd0, 32'd8, 32'd8);
    rst_n = 1'b1;
    #1 check("t6_req0_first", 32'(req0_ready), 32'd1);
    check("t6_req1_waits", 32'(req1_ready), 32'd0);
    @(posedge clk); @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    wait_rsp("t6", 20);
    check("t6_id", 32'(rsp_id), 32'd0);
    check("t6_result", rsp_result, 32'd4);
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
